mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 32, CPU byte-address width.
REQ-002 SHALL have parameter DATA_BITS, default 32, RAM word width; legal values 32 or 64; LANES = DATA_BITS/8, OFS = log2(LANES).
REQ-003 SHALL have parameter RAM_ADDR_BITS, default 10, RAM word-address width.
REQ-004 SHALL have parameter RAM_LATENCY, default 1, RAM read latency in cycles; legal values 1..4.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-006 SHALL have ports: req_valid input 1, request present; req_ready output 1, unit can accept.
REQ-007 SHALL have ports: req_addr input ADDR_BITS, byte address (ALU result); req_wdata input DATA_BITS, store data (register operand).
REQ-008 SHALL have ports: req_we input 1, 1 = store; req_size input 2, 00 byte / 01 half / 10 word / 11 dword; req_unsigned input 1, zero-extend loads.
REQ-009 SHALL have ports: resp_valid output 1; resp_ready input 1; resp_rdata output DATA_BITS, load result; resp_err output 1, misaligned or illegal size.
REQ-010 SHALL have ports: ram_en output 1; ram_we output 1; ram_addr output RAM_ADDR_BITS; ram_wdata output DATA_BITS; ram_sel output LANES, byte enables; ram_rdata input DATA_BITS.

Function
REQ-011 SHALL implement the FSM IDLE -> ACCESS -> RESP -> IDLE, plus the path IDLE -> RESP for error requests.
REQ-012 SHALL drive req_ready=1 only in IDLE; a request is accepted on a clock edge with req_valid && req_ready, and all req_* fields are latched at that edge.
REQ-013 SHALL flag an error when: size 01 with addr[0]!=0; size 10 with addr[1:0]!=0; size 11 with addr[2:0]!=0; or size 11 with DATA_BITS=32.
REQ-014 SHALL, for an error request, go IDLE -> RESP, assert no ram_en, and return resp_err=1 with resp_rdata=0.
REQ-015 SHALL compute ram_addr = req_addr[OFS+RAM_ADDR_BITS-1:OFS] and lane = req_addr[OFS-1:0]; higher address bits are ignored.
REQ-016 SHALL, in the first ACCESS cycle only, assert ram_en=1, assert ram_we=req_we, and drive ram_sel as the size mask (1, 3, 0xF or 0xFF lanes) shifted left by lane.
REQ-017 SHALL drive ram_wdata as the low size bytes of req_wdata shifted left by lane*8, with all other bytes zero.
REQ-018 SHALL hold ram_en, ram_we and ram_sel at 0 in every other cycle; ram_addr and ram_wdata hold their last values.
REQ-019 SHALL complete a store after a single ACCESS cycle and enter RESP with resp_rdata=0 and resp_err=0.
REQ-020 SHALL, for a load with ram_en asserted in cycle A, sample ram_rdata at the end of cycle A+RAM_LATENCY and enter RESP in the next cycle; a down-counter loaded with RAM_LATENCY times this.
REQ-021 SHALL form the load result by shifting ram_rdata right by lane*8, keeping size bytes, then sign-extending (req_unsigned=0) or zero-extending (req_unsigned=1) to DATA_BITS.
REQ-022 SHALL sign- or zero-extend dword loads on DATA_BITS=64 as identity.
REQ-023 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready=1, then return to IDLE at that edge.
REQ-024 SHALL drive req_ready=1 again in the cycle after the response handshake, with no back-to-back overlap.
REQ-025 SHALL ignore req_valid while not in IDLE, and latched fields SHALL NOT change.

Reset
REQ-026 SHALL, while rst_n=0, force state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, ram_en=0, ram_we=0, ram_sel=0, ram_addr=0, ram_wdata=0 and counter=0, independent of clk.
REQ-027 SHALL, on reset asserted mid-operation (ACCESS or RESP), abandon the transaction with no further ram_en and no response; the first accept is possible on the first rising edge after rst_n rises.

Verification
REQ-028 SHALL be covered by a half-store test: DATA_BITS=32, store size 01, addr 0x2, wdata 0x00000001 -> one cycle ram_en=1, ram_we=1, ram_addr=0, ram_sel=4'b1100, ram_wdata=0x00010000; resp_err=0.
REQ-029 SHALL be covered by a byte-store test: store size 00, addr 0x4, wdata 0x00001234 -> ram_addr=1, ram_sel=4'b0001, ram_wdata=0x00000034.
REQ-030 SHALL be covered by a byte-load test: RAM_LATENCY=2, load byte signed at addr 0x7, ram_rdata=0x80FF0000 -> resp_rdata=0xFFFFFF80, resp_valid exactly 3 cycles after the ram_en cycle; the same load unsigned -> 0x00000080.
REQ-031 SHALL be covered by a misalignment test: word load at addr 0x6, and dword at DATA_BITS=32 -> ram_en never asserts, resp_err=1, resp_rdata=0, resp_valid one cycle after accept.
REQ-032 SHALL be covered by a backpressure test: resp_ready=0 for 5 cycles -> resp_* stable, req_ready=0, new req_valid ignored; resp_ready=1 -> IDLE next cycle.
REQ-033 SHALL be covered by a reset mid-load test: rst_n low during the ACCESS wait -> all outputs reach their reset values immediately and no response appears after release.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between a CPU pipeline and a single-port byte-lane RAM.
// Latency: stores respond 2 cycles after accept, loads RAM_LATENCY+2, errors 1.
// Backpressure: one transaction in flight; req_ready only in IDLE, response held until resp_ready.
module mem_access_unit #(
  parameter int ADDR_BITS     = 32,
  parameter int DATA_BITS     = 32,
  parameter int RAM_ADDR_BITS = 10,
  parameter int RAM_LATENCY   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_BITS-1:0]     req_addr,
  input  logic [DATA_BITS-1:0]     req_wdata,
  input  logic                     req_we,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_BITS-1:0]     resp_rdata,
  output logic                     resp_err,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic [DATA_BITS-1:0]     ram_wdata,
  output logic [DATA_BITS/8-1:0]   ram_sel,
  input  logic [DATA_BITS-1:0]     ram_rdata
);

  localparam int LANES = DATA_BITS / 8;
  localparam int OFS   = $clog2(LANES);
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // latched request
  logic                     r_first;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_we;
  logic                     r_unsigned;
  logic [1:0]               r_size;
  logic [OFS-1:0]           r_lane;
  logic [LANES-1:0]         r_sel;
  logic [RAM_ADDR_BITS-1:0] r_ram_addr;
  logic [DATA_BITS-1:0]     r_ram_wdata;
  logic [DATA_BITS-1:0]     r_rdata;
  logic                     r_err;

  logic                     w_accept;
  logic                     w_req_err;
  logic [OFS-1:0]           w_req_lane;
  logic [LANES-1:0]         w_req_mask;
  logic [DATA_BITS-1:0]     w_req_bmask;
  logic [DATA_BITS-1:0]     w_req_wdata_sh;
  logic [DATA_BITS-1:0]     w_ld_shift;
  logic [DATA_BITS-1:0]     w_ld_bmask;
  logic                     w_ld_sign;
  logic [DATA_BITS-1:0]     w_ld_result;
  logic                     w_unused_addr;

  // Lane-enable pattern for an access size, before lane alignment.
  function automatic logic [LANES-1:0] f_size_mask(input logic [1:0] size);
    logic [LANES-1:0] m;
    m = '0;
    case (size)
      2'b00:   m = LANES'(1);
      2'b01:   m = LANES'(3);
      2'b10:   m = LANES'(15);
      default: m = '1;
    endcase
    return m;
  endfunction

  // Expand a lane-enable pattern into a per-bit mask.
  function automatic logic [DATA_BITS-1:0] f_lanes_to_bits(input logic [LANES-1:0] m);
    logic [DATA_BITS-1:0] b;
    b = '0;
    for (int i = 0; i < LANES; i++) begin
      b[i*8 +: 8] = {8{m[i]}};
    end
    return b;
  endfunction

  assign w_accept       = req_valid && (r_state == S_IDLE);
  assign w_req_lane     = req_addr[OFS-1:0];
  assign w_req_mask     = f_size_mask(req_size);
  assign w_req_bmask    = f_lanes_to_bits(w_req_mask);
  assign w_req_wdata_sh = (req_wdata & w_req_bmask) << {w_req_lane, 3'b000};
  // Bits above the RAM word address are intentionally dropped.
  assign w_unused_addr  = ^req_addr;

  // Alignment / size legality check on the incoming request.
  always_comb begin
    w_req_err = 1'b0;
    case (req_size)
      2'b01:   w_req_err = req_addr[0];
      2'b10:   w_req_err = |req_addr[1:0];
      2'b11:   w_req_err = (|req_addr[2:0]) || (DATA_BITS == 32);
      default: w_req_err = 1'b0;
    endcase
  end

  // Load result: align the addressed lanes down, then sign- or zero-extend.
  always_comb begin
    w_ld_shift = ram_rdata >> {r_lane, 3'b000};
    w_ld_bmask = f_lanes_to_bits(f_size_mask(r_size));
    w_ld_sign  = 1'b0;
    case (r_size)
      2'b00:   w_ld_sign = w_ld_shift[7];
      2'b01:   w_ld_sign = w_ld_shift[15];
      2'b10:   w_ld_sign = w_ld_shift[31];
      default: w_ld_sign = w_ld_shift[DATA_BITS-1];
    endcase
    w_ld_result = (w_ld_shift & w_ld_bmask) |
                  (~w_ld_bmask & {DATA_BITS{w_ld_sign & ~r_unsigned}});
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; errors skip the RAM entirely.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_state_nxt = w_req_err ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request latching, latency countdown and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_first     <= 1'b0;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_unsigned  <= 1'b0;
      r_size      <= 2'b00;
      r_lane      <= '0;
      r_sel       <= '0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else if (w_accept) begin
      r_we       <= req_we;
      r_unsigned <= req_unsigned;
      r_size     <= req_size;
      r_lane     <= w_req_lane;
      r_first    <= !w_req_err;
      // Stores finish after one ACCESS cycle; loads wait for the RAM pipeline.
      r_cnt      <= req_we ? '0 : CNT_W'(RAM_LATENCY);
      if (w_req_err) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end else begin
        r_ram_addr  <= req_addr[OFS+RAM_ADDR_BITS-1:OFS];
        r_ram_wdata <= w_req_wdata_sh;
        r_sel       <= w_req_mask << w_req_lane;
      end
    end else if (r_state == S_ACCESS) begin
      r_first <= 1'b0;
      if (r_cnt == '0) begin
        r_rdata <= r_we ? '0 : w_ld_result;
        r_err   <= 1'b0;
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  // RAM strobes only in the first ACCESS cycle; address/data hold their last values.
  assign ram_en    = (r_state == S_ACCESS) && r_first;
  assign ram_we    = ram_en && r_we;
  assign ram_sel   = ram_en ? r_sel : '0;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_rdata;
  assign resp_err   = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (DATA_BITS=32, RAM_LATENCY=2).
// Expected values are hand-computed constants per vector.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_access_unit;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int RAW = 10;
  localparam int LAT = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_valid;
  logic           req_ready;
  logic [AW-1:0]  req_addr;
  logic [DW-1:0]  req_wdata;
  logic           req_we;
  logic [1:0]     req_size;
  logic           req_unsigned;
  logic           resp_valid;
  logic           resp_ready;
  logic [DW-1:0]  resp_rdata;
  logic           resp_err;
  logic           ram_en;
  logic           ram_we;
  logic [RAW-1:0] ram_addr;
  logic [DW-1:0]  ram_wdata;
  logic [DW/8-1:0] ram_sel;
  logic [DW-1:0]  ram_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(
    .ADDR_BITS(AW), .DATA_BITS(DW), .RAM_ADDR_BITS(RAW), .RAM_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_sel(ram_sel), .ram_rdata(ram_rdata)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-transaction observations (k = falling edges after the accept edge).
  int          en_cnt;
  int          en_k;
  int          resp_k;
  logic        cap_we;
  logic [RAW-1:0] cap_addr;
  logic [3:0]  cap_sel;
  logic [31:0] cap_wdata;
  logic [31:0] got_rdata;
  logic        got_err;
  logic        ready_after;

  task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
    en_cnt = 0; en_k = -1; resp_k = -1;
    cap_we = 1'b0; cap_addr = '0; cap_sel = '0; cap_wdata = '0;
    got_rdata = '0; got_err = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (ram_en) begin
        en_cnt++; en_k = k;
        cap_we = ram_we; cap_addr = ram_addr; cap_sel = ram_sel; cap_wdata = ram_wdata;
      end
      if (resp_valid) begin
        resp_k = k; got_rdata = resp_rdata; got_err = resp_err;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    ready_after = req_ready;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"},  req_ready,  1'b1);
    check({tag, "_resp_valid"}, resp_valid, 1'b0);
    check({tag, "_resp_err"},   resp_err,   1'b0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'h0);
    check({tag, "_ram_en"},     ram_en,     1'b0);
    check({tag, "_ram_we"},     ram_we,     1'b0);
    check({tag, "_ram_sel"},    ram_sel,    4'h0);
    check({tag, "_ram_addr"},   ram_addr,   10'h0);
    check({tag, "_ram_wdata"},  ram_wdata,  32'h0);
  endtask

  int seen_resp;
  int seen_en;

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0;
    req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    resp_ready = 1'b1; ram_rdata = '0;
    #2;
    check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Half store at byte 2.
    run_txn(1'b1, 2'b01, 1'b0, 32'h2, 32'h0000_0001);
    check("hs_en_cnt", en_cnt, 1);
    check("hs_en_k",   en_k,   1);
    check("hs_we",     cap_we, 1'b1);
    check("hs_addr",   cap_addr, 10'd0);
    check("hs_sel",    cap_sel,  4'b1100);
    check("hs_wdata",  cap_wdata, 32'h0001_0000);
    check("hs_resp_k", resp_k, 2);
    check("hs_err",    got_err, 1'b0);
    check("hs_rdata",  got_rdata, 32'h0);
    check("hs_ready",  ready_after, 1'b1);

    // Byte store at byte 4.
    run_txn(1'b1, 2'b00, 1'b0, 32'h4, 32'h0000_1234);
    check("bs_addr",   cap_addr, 10'd1);
    check("bs_sel",    cap_sel,  4'b0001);
    check("bs_wdata",  cap_wdata, 32'h0000_0034);
    check("bs_resp_k", resp_k, 2);

    // Loads from a word holding 0x80FF0000.
    ram_rdata = 32'h80FF_0000;
    run_txn(1'b0, 2'b00, 1'b0, 32'h7, 32'h0);
    check("lbs_en_cnt", en_cnt, 1);
    check("lbs_we",     cap_we, 1'b0);
    check("lbs_addr",   cap_addr, 10'd1);
    check("lbs_sel",    cap_sel, 4'b1000);
    check("lbs_lat",    resp_k - en_k, 3);
    check("lbs_rdata",  got_rdata, 32'hFFFF_FF80);
    check("lbs_err",    got_err, 1'b0);
    run_txn(1'b0, 2'b00, 1'b1, 32'h7, 32'h0);
    check("lbu_rdata",  got_rdata, 32'h0000_0080);
    run_txn(1'b0, 2'b01, 1'b0, 32'h2, 32'h0);
    check("lhs_sel",    cap_sel, 4'b1100);
    check("lhs_rdata",  got_rdata, 32'hFFFF_80FF);
    run_txn(1'b0, 2'b01, 1'b1, 32'h2, 32'h0);
    check("lhu_rdata",  got_rdata, 32'h0000_80FF);
    run_txn(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    check("lw_sel",     cap_sel, 4'b1111);
    check("lw_rdata",   got_rdata, 32'h80FF_0000);

    // Illegal requests never touch the RAM.
    run_txn(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
    check("mw_en_cnt", en_cnt, 0);
    check("mw_err",    got_err, 1'b1);
    check("mw_rdata",  got_rdata, 32'h0);
    check("mw_resp_k", resp_k, 1);
    run_txn(1'b0, 2'b11, 1'b0, 32'h0, 32'h0);
    check("md_en_cnt", en_cnt, 0);
    check("md_err",    got_err, 1'b1);
    check("md_resp_k", resp_k, 1);
    run_txn(1'b1, 2'b01, 1'b0, 32'h1, 32'hFFFF);
    check("mh_en_cnt", en_cnt, 0);
    check("mh_err",    got_err, 1'b1);
    // A legal access right after an error still works.
    run_txn(1'b1, 2'b10, 1'b0, 32'hC, 32'hCAFE_F00D);
    check("post_err_sel",   cap_sel, 4'b1111);
    check("post_err_addr",  cap_addr, 10'd3);
    check("post_err_wdata", cap_wdata, 32'hCAFE_F00D);

    // Backpressure: response held while resp_ready is low.
    resp_ready = 1'b0;
    ram_rdata  = 32'h1234_5678;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    seen_resp = 0;
    for (int k = 0; k < 20; k++) begin
      if (resp_valid) begin
        seen_resp = 1;
        break;
      end
      @(negedge clk);
    end
    check("bp_resp_seen", seen_resp, 1);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10;
    req_addr = 32'h8; req_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", resp_valid, 1'b1);
      check("bp_rdata", resp_rdata, 32'h1234_5678);
      check("bp_err",   resp_err, 1'b0);
      check("bp_ready", req_ready, 1'b0);
      check("bp_ram_en", ram_en, 1'b0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_ready", req_ready, 1'b1);
    check("bp_idle_valid", resp_valid, 1'b0);
    check("bp_ram_addr",   ram_addr, 10'd0);

    // Reset while a load is waiting on the RAM.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h7; req_wdata = 32'hFFFF_FFFF;
    @(negedge clk);
    req_valid = 1'b0;
    check("rml_en",   ram_en, 1'b1);
    check("rml_addr", ram_addr, 10'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rml");
    @(negedge clk);
    rst_n = 1'b1;
    seen_resp = 0;
    seen_en   = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid) seen_resp++;
      if (ram_en)     seen_en++;
    end
    check("rml_no_resp", seen_resp, 0);
    check("rml_no_en",   seen_en, 0);
    check("rml_ready",   req_ready, 1'b1);

    // Unit is usable again after reset.
    run_txn(1'b1, 2'b00, 1'b0, 32'h4, 32'h0000_1234);
    check("after_rst_sel",   cap_sel, 4'b0001);
    check("after_rst_wdata", cap_wdata, 32'h0000_0034);
    check("after_rst_resp",  resp_k, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
